// File: rtl/cbf_output_stage.sv
// Output stage for the CBF filter: offset-binary to two's complement, boxcar
// decimation by DECIM, and a show-ahead valid/ready FIFO with drop accounting.
module cbf_output_stage #(
  parameter int unsigned IN_W       = 16,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_W-1:0]               in_data,
  input  logic                          in_valid,
  input  logic                          clr,
  output logic [IN_W-1:0]               m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  output logic [7:0]                    drop_cnt
);

  localparam int unsigned SH    = $clog2(DECIM);
  localparam int unsigned ACC_W = IN_W + SH;
  localparam int unsigned PH_W  = (SH > 0) ? SH : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;

  logic signed [IN_W-1:0]  s;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [PH_W-1:0]         phase;
  logic                    last;
  logic [IN_W-1:0]         word;

  logic [IN_W-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [LW-1:0]           level_nxt;
  logic                    push_req;
  logic                    push_ok;
  logic                    pop;
  logic                    full;
  logic                    drop;

  // Conversion, accumulation and group-completion decode
  always_comb begin
    s        = {~in_data[IN_W-1], in_data[IN_W-2:0]};
    sum      = acc + ACC_W'(s);
    word     = IN_W'(sum >>> SH);
    last     = (phase == PH_W'(DECIM - 1));
    push_req = in_valid & ~clr & last;
  end

  // FIFO control; full is derived from the wrap bit of the pointers
  always_comb begin
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop     = m_valid & m_ready;
    push_ok = push_req & (~full | pop);
    drop    = push_req & ~push_ok;
    level_nxt = level;
    case ({push_ok, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  assign m_data = mem[rd_ptr[AW-1:0]];

  // Decimation accumulator and phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (clr) begin
      acc   <= '0;
      phase <= '0;
    end else if (in_valid) begin
      if (last) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + PH_W'(1);
      end
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= word;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      level   <= level_nxt;
      m_valid <= (level_nxt != '0);
    end
  end

  // Sticky overflow and saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cbf_output_stage.sv
// Bench for cbf_output_stage: directed test-plan steps followed by random
// traffic, all checked against a queue-based reference model.
module tb_cbf_output_stage;

  localparam int IN_W  = 16;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        clr;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  level;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int q[$];
  int grp[$];
  bit movf;
  int mdc;

  cbf_output_stage #(.IN_W(IN_W), .DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clr(clr),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level),
    .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("drop_cnt", 32'(drop_cnt), 32'(mdc));
  endtask

  // Model one clock edge from the currently driven inputs
  task automatic model_edge();
    bit pop, full, push;
    int w;
    logic signed [15:0] sv;
    int sum;
    full = (q.size() == DEPTH);
    pop  = m_ready && (q.size() != 0);
    push = 0;
    w    = 0;
    if (clr) begin
      grp.delete();
      movf = 0;
      mdc  = 0;
    end else if (in_valid) begin
      sv = in_data ^ 16'h8000;
      grp.push_back(int'(sv));
      if (grp.size() == DECIM) begin
        sum = 0;
        foreach (grp[i]) sum += grp[i];
        w = (sum >>> $clog2(DECIM)) & 32'hFFFF;
        push = 1;
        grp.delete();
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (!full || pop) q.push_back(w);
      else begin
        movf = 1;
        if (mdc < 255) mdc++;
      end
    end
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit r, input bit c);
    @(negedge clk);
    in_valid = v; in_data = d; m_ready = r; clr = c;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; clr = 0;
    rst = 0;
    #1;
    q.delete(); grp.delete(); movf = 0; mdc = 0;
    check_all();
    chk("rst_m_data", 32'(m_data), 32'h0);
    #1 rst = 1;
  endtask

  task automatic group4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d, input bit r);
    step(1, a, r, 0); step(1, b, r, 0); step(1, c, r, 0); step(1, d, r, 0);
  endtask

  initial begin
    rst = 0; in_data = '0; in_valid = 0; clr = 0; m_ready = 0;
    #12;
    do_reset();

    // zero mean: one word, valid exactly one cycle
    group4(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1);
    chk("zm_valid", 32'(m_valid), 32'h1);
    chk("zm_data", 32'(m_data), 32'h0);
    step(0, 16'h0, 1, 0);
    chk("zm_valid_low", 32'(m_valid), 32'h0);

    // sign and floor behaviour
    group4(16'h8004, 16'h8004, 16'h8004, 16'h8004, 1);
    chk("sf_pos", 32'(m_data), 32'h0004);
    group4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1);
    chk("sf_neg", 32'(m_data), 32'hFFFF);
    group4(16'h8001, 16'h8000, 16'h8000, 16'h8000, 1);
    chk("sf_floor_pos", 32'(m_data), 32'h0000);
    group4(16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 1);
    chk("sf_floor_neg", 32'(m_data), 32'hFFFF);
    step(0, 16'h0, 1, 0);

    // gapped input
    step(1, 16'h8008, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 16'h0, 1, 0);
      chk("gap_quiet", 32'(m_valid), 32'h0);
    end
    step(1, 16'h8008, 1, 0); step(1, 16'h8008, 1, 0); step(1, 16'h8008, 1, 0);
    chk("gap_data", 32'(m_data), 32'h0008);
    step(0, 16'h0, 1, 0);

    // back-pressure: 10 groups into an 8-deep FIFO
    for (int k = 1; k <= 10; k++) begin
      logic [15:0] v;
      v = 16'h8000 + 16'(k);
      group4(v, v, v, v, 0);
    end
    chk("bp_level", 32'(level), 32'd8);
    chk("bp_ovf", 32'(ovf), 32'h1);
    chk("bp_drops", 32'(drop_cnt), 32'd2);
    for (int k = 1; k <= 8; k++) begin
      chk("bp_order", 32'(m_data), 32'(k));
      step(0, 16'h0, 1, 0);
    end
    chk("bp_empty", 32'(level), 32'd0);

    // simultaneous push and pop while full
    for (int k = 1; k <= 8; k++) group4(16'h8020, 16'h8020, 16'h8020, 16'h8020, 0);
    step(1, 16'h8030, 0, 0); step(1, 16'h8030, 0, 0); step(1, 16'h8030, 0, 0);
    step(1, 16'h8030, 1, 0);
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_drops", 32'(drop_cnt), 32'd2);
    chk("pp_ovf", 32'(ovf), 32'h1);

    // clr keeps FIFO contents, clears status
    step(0, 16'h0, 0, 1);
    chk("clr_ovf", 32'(ovf), 32'h0);
    chk("clr_drops", 32'(drop_cnt), 32'd0);
    chk("clr_level", 32'(level), 32'd8);
    chk("clr_head", 32'(m_data), 32'h0020);
    for (int k = 0; k < 8; k++) step(0, 16'h0, 1, 0);

    // reset mid-group discards the partial sum
    step(1, 16'h8100, 1, 0); step(1, 16'h8100, 1, 0);
    do_reset();
    group4(16'h8010, 16'h8010, 16'h8010, 16'h8010, 1);
    chk("rst_group", 32'(m_data), 32'h0010);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] d;
      int sel;
      sel = int'($urandom_range(0, 3));
      d = 16'($urandom);
      if (sel == 0) d = 16'h7FF0 | 16'($urandom_range(0, 15));
      if (sel == 1) d = 16'h8000 + 16'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 5,
                $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
